debounce_array: RTL and testbench

//  N_CH-channel button/switch debouncer with 2-FF synchroniser per channel,

---
 rtl/debounce_pkg.sv | 27 ++
 rtl/debounce_array_if.sv | 28 ++
 rtl/debounce_chan.sv | 82 ++++++++
 rtl/debounce_array.sv | 48 ++++
 tb/tb_debounce_array.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and elaboration-time helpers for the debounce array.
package debounce_pkg;

  localparam int unsigned DEF_STABLE_CNT = 1000000;
  localparam int unsigned DEF_HOLD_CNT   = 50000000;

  // Smallest w such that 2**w >= v.
  function automatic int unsigned clog2(input longint unsigned v);
    for (int unsigned i = 0; i < 64; i++) begin
      if ((64'd1 << i) >= v) return i;
    end
    return 64;
  endfunction

  // Stable counter must count 0..STABLE_CNT-1, and at least two cycles of agreement are required.
  function automatic bit stable_params_ok(input int unsigned stable_cnt,
                                          input int unsigned cnt_w);
    return (stable_cnt >= 2) && (cnt_w >= clog2(longint'(stable_cnt)));
  endfunction

  // Hold counter must be able to reach HOLD_CNT itself (it saturates there).
  function automatic bit hold_params_ok(input int unsigned hold_cnt,
                                        input int unsigned hold_w);
    return (hold_cnt >= 1) && (hold_w >= clog2(longint'(hold_cnt) + 1));
  endfunction

endpackage

// File: rtl/debounce_array_if.sv
// Button-side and debounced-side signal bundle for debounce_array.
// master: the board/input side (drives button_in, consumes events).
// slave:  the debouncer itself.
interface debounce_array_if #(
  parameter int unsigned N_CH = 4
);
  logic [N_CH-1:0] button_in;
  logic [N_CH-1:0] db_out;
  logic [N_CH-1:0] rise_o;
  logic [N_CH-1:0] fall_o;
  logic [N_CH-1:0] hold_o;

  modport master (
    output button_in,
    input  db_out,
    input  rise_o,
    input  fall_o,
    input  hold_o
  );

  modport slave (
    input  button_in,
    output db_out,
    output rise_o,
    output fall_o,
    output hold_o
  );
endinterface

// File: rtl/debounce_chan.sv
// One debounce channel: 2-FF synchroniser, stable-time counter, rise/fall
// event pulses and, when DEBOUNCE_HOLD_EN is defined, a long-press detector.
// Without DEBOUNCE_HOLD_EN the hold logic is not built and hold_o is 0.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CNT = DEF_STABLE_CNT,
  parameter int unsigned CNT_W      = 20,
  parameter logic        RST_VAL    = 1'b0,
  parameter int unsigned HOLD_CNT   = DEF_HOLD_CNT,
  parameter int unsigned HOLD_W     = 26
) (
  input  logic clk,
  input  logic n_reset,
  input  logic button_in,
  output logic db_out,
  output logic rise_o,
  output logic fall_o,
  output logic hold_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Synchronise the raw input and accept a new level only after it has
  // differed from db_out for STABLE_CNT consecutive cycles.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      sync1  <= RST_VAL;
      sync2  <= RST_VAL;
      db_out <= RST_VAL;
      cnt    <= '0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      sync1  <= button_in;
      sync2  <= sync1;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      if (sync2 == db_out) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db_out <= sync2;
        cnt    <= '0;
        rise_o <= sync2;
        fall_o <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef DEBOUNCE_HOLD_EN
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CNT);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CNT - 1);

  logic [HOLD_W-1:0] hold_cnt;

  // Count cycles of db_out==1; pulse once when the count reaches HOLD_CNT,
  // then sit saturated until release clears it.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      hold_cnt <= '0;
      hold_o   <= 1'b0;
    end else begin
      hold_o <= 1'b0;
      if (!db_out) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
        if (hold_cnt == HOLD_LAST) hold_o <= 1'b1;
      end
    end
  end
`else
  assign hold_o = 1'b0;
`endif

endmodule

// File: rtl/debounce_array.sv
// N_CH independent debounce channels behind a debounce_array_if bundle.
// Optional long-press detection is enabled by defining DEBOUNCE_HOLD_EN.
module debounce_array
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned STABLE_CNT = DEF_STABLE_CNT,
  parameter int unsigned CNT_W      = 20,
  parameter logic        RST_VAL    = 1'b0,
  parameter int unsigned HOLD_CNT   = DEF_HOLD_CNT,
  parameter int unsigned HOLD_W     = 26
) (
  input  logic                    clk,
  input  logic                    n_reset,
  debounce_array_if.slave         bus
);

  if (!stable_params_ok(STABLE_CNT, CNT_W)) begin : g_bad_stable
    $error("debounce_array: STABLE_CNT=%0d must be >=2 and fit in CNT_W=%0d bits",
           STABLE_CNT, CNT_W);
  end

`ifdef DEBOUNCE_HOLD_EN
  if (!hold_params_ok(HOLD_CNT, HOLD_W)) begin : g_bad_hold
    $error("debounce_array: HOLD_CNT=%0d does not fit in HOLD_W=%0d bits",
           HOLD_CNT, HOLD_W);
  end
`endif

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    debounce_chan #(
      .STABLE_CNT (STABLE_CNT),
      .CNT_W      (CNT_W),
      .RST_VAL    (RST_VAL),
      .HOLD_CNT   (HOLD_CNT),
      .HOLD_W     (HOLD_W)
    ) u_chan (
      .clk       (clk),
      .n_reset   (n_reset),
      .button_in (bus.button_in[i]),
      .db_out    (bus.db_out[i]),
      .rise_o    (bus.rise_o[i]),
      .fall_o    (bus.fall_o[i]),
      .hold_o    (bus.hold_o[i])
    );
  end

endmodule

// File: tb/tb_debounce_array.sv
// Directed bench for debounce_array (N_CH=4, STABLE_CNT=8, HOLD_CNT=20).
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns after
// the edge that should have produced them. Event pulses are also tallied
// on the falling edge and compared with expected totals at the end.
module tb_debounce_array;

`ifdef DEBOUNCE_HOLD_EN
  localparam logic [3:0] HOLD_PULSE = 4'b0001;
  localparam int         HOLD_TOTAL = 2;
`else
  localparam logic [3:0] HOLD_PULSE = 4'b0000;
  localparam int         HOLD_TOTAL = 0;
`endif

  logic clk;
  logic n_reset;
  int   n_checks;
  int   n_fail;
  int   rise_cnt [4];
  int   fall_cnt [4];
  int   hold_cnt [4];
  int   both_cnt;

  debounce_array_if #(.N_CH(4)) bus ();

  debounce_array #(
    .N_CH       (4),
    .STABLE_CNT (8),
    .CNT_W      (4),
    .RST_VAL    (1'b0),
    .HOLD_CNT   (20),
    .HOLD_W     (6)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tally event pulses per channel.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.rise_o[i]) rise_cnt[i]++;
      if (bus.fall_o[i]) fall_cnt[i]++;
      if (bus.hold_o[i]) hold_cnt[i]++;
      if (bus.rise_o[i] && bus.fall_o[i]) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Input changed just before this call: new level is first seen at the
  // next edge (E=1), so db_out and the pulse land on edge 1+1+8 = 10.
  task automatic settle(input string tag, input logic [3:0] db_pre, input logic [3:0] db_post,
                        input logic [3:0] rise_exp, input logic [3:0] fall_exp);
    repeat (9) tick();
    check({tag, "_pre_db"}, 32'(bus.db_out), 32'(db_pre));
    check({tag, "_pre_pulse"}, 32'(bus.rise_o | bus.fall_o), 32'h0);
    tick();
    check({tag, "_db"}, 32'(bus.db_out), 32'(db_post));
    check({tag, "_rise"}, 32'(bus.rise_o), 32'(rise_exp));
    check({tag, "_fall"}, 32'(bus.fall_o), 32'(fall_exp));
    tick();
    check({tag, "_post_pulse"}, 32'(bus.rise_o | bus.fall_o), 32'h0);
    check({tag, "_post_db"}, 32'(bus.db_out), 32'(db_post));
  endtask

  task automatic hard_reset(input logic [3:0] btn);
    n_reset = 1'b0;
    bus.button_in = btn;
    repeat (3) tick();
    n_reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int exp_rise [4];
    int exp_fall [4];
    int exp_hold [4];
    exp_rise = '{5, 2, 2, 2};
    exp_fall = '{4, 1, 1, 1};
    exp_hold = '{HOLD_TOTAL, 0, 0, 0};
    n_checks = 0;
    n_fail   = 0;
    both_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
      hold_cnt[i] = 0;
    end

    // 1: reset with all inputs high, then release.
    n_reset = 1'b0;
    bus.button_in = 4'hF;
    repeat (5) tick();
    check("rst_db", 32'(bus.db_out), 32'h0);
    check("rst_pulses", 32'(bus.rise_o | bus.fall_o | bus.hold_o), 32'h0);
    n_reset = 1'b1;
    settle("t1_release", 4'h0, 4'hF, 4'hF, 4'h0);

    // Back to a known all-low state.
    hard_reset(4'h0);
    tick();
    check("rst2_db", 32'(bus.db_out), 32'h0);

    // 2: clean press / release on ch0.
    bus.button_in = 4'b0001;
    settle("t2_press", 4'h0, 4'b0001, 4'b0001, 4'h0);
    bus.button_in = 4'b0000;
    settle("t2_release", 4'b0001, 4'h0, 4'h0, 4'b0001);

    // 3: ch1 bounces with 3-cycle runs, then settles high.
    for (int i = 0; i < 10; i++) begin
      bus.button_in[1] = ~bus.button_in[1];
      repeat (3) tick();
    end
    check("t3_bounce_db", 32'(bus.db_out), 32'h0);
    bus.button_in[1] = 1'b1;
    settle("t3_press", 4'h0, 4'b0010, 4'b0010, 4'h0);
    bus.button_in[1] = 1'b0;
    settle("t3_release", 4'b0010, 4'h0, 4'h0, 4'b0010);

    // 4: 7-cycle glitch is rejected, 8-cycle pulse is accepted.
    bus.button_in[2] = 1'b1;
    repeat (7) tick();
    bus.button_in[2] = 1'b0;
    repeat (12) tick();
    check("t4_glitch_db", 32'(bus.db_out), 32'h0);
    bus.button_in[2] = 1'b1;
    repeat (8) tick();
    bus.button_in[2] = 1'b0;
    tick();
    check("t4_e9_db", 32'(bus.db_out), 32'h0);
    tick();
    check("t4_e10_rise", 32'(bus.rise_o), 32'b0100);
    check("t4_e10_db", 32'(bus.db_out), 32'b0100);
    repeat (7) tick();
    check("t4_e17_db", 32'(bus.db_out), 32'b0100);
    tick();
    check("t4_e18_fall", 32'(bus.fall_o), 32'b0100);
    check("t4_e18_db", 32'(bus.db_out), 32'h0);
    tick();

    // 5: ch0 and ch3 change on the same edge.
    bus.button_in = 4'b1001;
    settle("t5_press", 4'h0, 4'b1001, 4'b1001, 4'h0);
    bus.button_in = 4'b0000;
    settle("t5_release", 4'b1001, 4'h0, 4'h0, 4'b1001);

    // 6: reset at cnt=5 discards progress; count restarts after release.
    bus.button_in = 4'b0001;
    repeat (7) tick();
    n_reset = 1'b0;
    tick();
    check("t6_rst_db", 32'(bus.db_out), 32'h0);
    check("t6_rst_rise", 32'(bus.rise_o), 32'h0);
    n_reset = 1'b1;
    settle("t6_restart", 4'h0, 4'b0001, 4'b0001, 4'h0);
    repeat (18) tick();
    check("t6_hold_early", 32'(bus.hold_o), 32'h0);
    tick();
    check("t6_hold", 32'(bus.hold_o), 32'(HOLD_PULSE));
    tick();
    check("t6_hold_after", 32'(bus.hold_o), 32'h0);
    repeat (20) tick();
    bus.button_in = 4'b0000;
    settle("t6_release", 4'b0001, 4'h0, 4'h0, 4'b0001);

    // Re-press re-arms the long-press detector.
    bus.button_in = 4'b0001;
    settle("t6_repress", 4'h0, 4'b0001, 4'b0001, 4'h0);
    repeat (19) tick();
    check("t6_rehold", 32'(bus.hold_o), 32'(HOLD_PULSE));
    tick();
    check("t6_rehold_after", 32'(bus.hold_o), 32'h0);
    bus.button_in = 4'b0000;
    settle("t6_rerelease", 4'b0001, 4'h0, 4'h0, 4'b0001);

    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rise_total_ch%0d", i), 32'(rise_cnt[i]), 32'(exp_rise[i]));
      check($sformatf("fall_total_ch%0d", i), 32'(fall_cnt[i]), 32'(exp_fall[i]));
      check($sformatf("hold_total_ch%0d", i), 32'(hold_cnt[i]), 32'(exp_hold[i]));
    end
    check("rise_fall_overlap", 32'(both_cnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
